// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with result select and architectural HI/LO
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_odata,
  input  logic [31:0] ex_clz_data,
  input  logic [63:0] ex_mult_data,
  input  logic [31:0] ex_div_r,
  input  logic [31:0] ex_div_q,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rf_we,
  input  logic        ex_mem_we,
  input  logic        ex_mem_re,
  input  logic [2:0]  ex_res_sel,
  input  logic [2:0]  ex_hilo_op,
  output logic        mem_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_rd_addr,
  output logic        mem_rf_we,
  output logic        mem_mem_we,
  output logic        mem_mem_re,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic        load;
  logic [31:0] res;
  logic        valid_q, valid_d, rf_we_q, rf_we_d, mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [31:0] pc_q, pc_d, result_q, result_d, sd_q, sd_d, hi_q, hi_d, lo_q, lo_d;
  logic [4:0]  rd_q, rd_d;
  // Result select reads the current HI/LO so a producer in this stage feeds MFHI/MFLO without forwarding
  always_comb begin
    load = !stall && !flush && ex_valid;
    res  = ex_res_sel == 3'd1 ? ex_clz_data :
           ex_res_sel == 3'd2 ? hi_q :
           ex_res_sel == 3'd3 ? lo_q :
           ex_res_sel == 3'd4 ? ex_mult_data[31:0] : ex_alu_odata;
  end
  // Next state: hold on stall, capture on load, otherwise a bubble of zeros
  always_comb begin
    valid_d  = stall ? valid_q  : load;
    pc_d     = stall ? pc_q     : load ? ex_pc : 32'd0;
    result_d = stall ? result_q : load ? res : 32'd0;
    sd_d     = stall ? sd_q     : load ? ex_rt_data : 32'd0;
    rd_d     = stall ? rd_q     : load ? ex_rd_addr : 5'd0;
    rf_we_d  = stall ? rf_we_q  : load && ex_rf_we;
    mem_we_d = stall ? mem_we_q : load && ex_mem_we;
    mem_re_d = stall ? mem_re_q : load && ex_mem_re;
    hi_d     = !load ? hi_q :
               ex_hilo_op == 3'd1 ? ex_mult_data[63:32] :
               ex_hilo_op == 3'd2 ? ex_div_r :
               ex_hilo_op == 3'd3 ? ex_rs_data : hi_q;
    lo_d     = !load ? lo_q :
               ex_hilo_op == 3'd1 ? ex_mult_data[31:0] :
               ex_hilo_op == 3'd2 ? ex_div_q :
               ex_hilo_op == 3'd4 ? ex_rs_data : lo_q;
  end
  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      result_q <= '0;
      sd_q     <= '0;
      rd_q     <= '0;
      rf_we_q  <= 1'b0;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      sd_q     <= sd_d;
      rd_q     <= rd_d;
      rf_we_q  <= rf_we_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
  assign mem_valid      = valid_q;
  assign mem_pc         = pc_q;
  assign mem_result     = result_q;
  assign mem_store_data = sd_q;
  assign mem_rd_addr    = rd_q;
  assign mem_rf_we      = rf_we_q;
  assign mem_mem_we     = mem_we_q;
  assign mem_mem_re     = mem_re_q;
  assign hi             = hi_q;
  assign lo             = lo_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage against a behavioural model
module tb_ex_mem_stage;
  logic        clk = 0, rst = 1, stall, flush, ex_valid;
  logic [31:0] ex_pc, ex_alu_odata, ex_clz_data, ex_div_r, ex_div_q, ex_rs_data, ex_rt_data;
  logic [63:0] ex_mult_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rf_we, ex_mem_we, ex_mem_re;
  logic [2:0]  ex_res_sel, ex_hilo_op;
  logic        mem_valid, mem_rf_we, mem_mem_we, mem_mem_re;
  logic [31:0] mem_pc, mem_result, mem_store_data, hi, lo;
  logic [4:0]  mem_rd_addr;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, result, sd;
    logic [4:0]  rd;
    logic        rfwe, mwe, mre;
    logic [31:0] hi, lo;
  } st_t;

  st_t m, q[$];
  int total = 0, bad = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_alu_odata(ex_alu_odata), .ex_clz_data(ex_clz_data),
    .ex_mult_data(ex_mult_data), .ex_div_r(ex_div_r), .ex_div_q(ex_div_q),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_rd_addr(ex_rd_addr),
    .ex_rf_we(ex_rf_we), .ex_mem_we(ex_mem_we), .ex_mem_re(ex_mem_re),
    .ex_res_sel(ex_res_sel), .ex_hilo_op(ex_hilo_op),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_rd_addr(mem_rd_addr),
    .mem_rf_we(mem_rf_we), .mem_mem_we(mem_mem_we), .mem_mem_re(mem_mem_re),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic st_t actual();
    return '{mem_valid, mem_pc, mem_result, mem_store_data, mem_rd_addr,
             mem_rf_we, mem_mem_we, mem_mem_re, hi, lo};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: the state that should be visible after the coming edge
  task automatic go();
    st_t n;
    n = m;
    if (!stall) begin
      n = '0;
      n.hi = m.hi;
      n.lo = m.lo;
      if (ex_valid && !flush) begin
        n.valid = 1;
        n.pc = ex_pc;
        n.sd = ex_rt_data;
        n.rd = ex_rd_addr;
        n.rfwe = ex_rf_we;
        n.mwe = ex_mem_we;
        n.mre = ex_mem_re;
        case (ex_res_sel)
          3'd1: n.result = ex_clz_data;
          3'd2: n.result = m.hi;
          3'd3: n.result = m.lo;
          3'd4: n.result = ex_mult_data[31:0];
          default: n.result = ex_alu_odata;
        endcase
        case (ex_hilo_op)
          3'd1: {n.hi, n.lo} = ex_mult_data;
          3'd2: begin n.hi = ex_div_r; n.lo = ex_div_q; end
          3'd3: n.hi = ex_rs_data;
          3'd4: n.lo = ex_rs_data;
          default: ;
        endcase
      end
    end
    m = n;
    q.push_back(n);
    @(negedge clk);
  endtask

  task automatic clr();
    {stall, flush} = 0;
    ex_valid = 1;
    {ex_pc, ex_alu_odata, ex_clz_data, ex_div_r, ex_div_q, ex_rs_data, ex_rt_data} = '0;
    ex_mult_data = '0;
    ex_rd_addr = 0;
    {ex_rf_we, ex_mem_we, ex_mem_re} = 0;
    ex_res_sel = 0;
    ex_hilo_op = 0;
  endtask

  task automatic rnd();
    stall = $urandom_range(0, 4) == 0;
    flush = $urandom_range(0, 6) == 0;
    ex_valid = $urandom_range(0, 4) != 0;
    ex_pc = $urandom; ex_alu_odata = $urandom; ex_clz_data = $urandom_range(0, 32);
    ex_mult_data = {$urandom, $urandom}; ex_div_r = $urandom; ex_div_q = $urandom;
    ex_rs_data = $urandom; ex_rt_data = $urandom; ex_rd_addr = 5'($urandom);
    ex_rf_we = 1'($urandom); ex_mem_we = 1'($urandom); ex_mem_re = 1'($urandom);
    ex_res_sel = 3'($urandom); ex_hilo_op = 3'($urandom);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge
  task automatic mid_reset();
    #2 rst = 1;
    #1 chk("async_reset", 64'(actual()), 64'(st_t'('0)));
    m = '0;
    @(negedge clk);
    rst = 0;
  endtask

  // Monitor: compare DUT against each expected entry just after the edge it belongs to
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        total++;
        if (actual() !== e) begin
          bad++;
          $display("FAIL scoreboard got=%h expected=%h", actual(), e);
        end
      end
    end
  end

  initial begin
    logic [31:0] h0, l0, r0;
    clr();
    m = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'(actual()), 64'(st_t'('0)));
    rst = 0;
    // Build nonzero state, then reset asynchronously mid-cycle
    ex_hilo_op = 1; ex_mult_data = 64'h1111_2222_3333_4444; ex_alu_odata = 32'h99; ex_rf_we = 1;
    go();
    mid_reset();
    clr();
    ex_alu_odata = 32'h1234_5678; ex_rd_addr = 5; ex_rf_we = 1;
    go();
    chk("alu_result", mem_result, 32'h1234_5678);
    chk("alu_rd", mem_rd_addr, 5);
    chk("alu_valid", mem_valid, 1);
    // MULT then MFHI back to back
    clr();
    ex_hilo_op = 1; ex_mult_data = 64'hDEAD_BEEF_0000_0007;
    go();
    chk("mult_hi", hi, 32'hDEAD_BEEF);
    chk("mult_lo", lo, 7);
    clr();
    ex_res_sel = 2;
    go();
    chk("mfhi", mem_result, 32'hDEAD_BEEF);
    // DIV, MTLO, MFLO
    clr();
    ex_hilo_op = 2; ex_div_r = 3; ex_div_q = 32'h10;
    go();
    chk("div_hi", hi, 3);
    chk("div_lo", lo, 32'h10);
    clr();
    ex_hilo_op = 4; ex_rs_data = 32'hAA;
    go();
    chk("mtlo_lo", lo, 32'hAA);
    chk("mtlo_hi", hi, 3);
    clr();
    ex_res_sel = 3;
    go();
    chk("mflo", mem_result, 32'hAA);
    // Stall three cycles over a MULT, then release
    r0 = mem_result; h0 = hi; l0 = lo;
    clr();
    stall = 1; ex_hilo_op = 1; ex_mult_data = 64'hCAFE_0001_BEEF_0002; ex_alu_odata = 32'h77;
    repeat (3) begin
      go();
      chk("stall_result", mem_result, r0);
      chk("stall_hilo", {hi, lo}, {h0, l0});
    end
    stall = 0;
    go();
    chk("stall_release_hilo", {hi, lo}, 64'hCAFE_0001_BEEF_0002);
    ex_hilo_op = 0;
    go();
    chk("mult_once", {hi, lo}, 64'hCAFE_0001_BEEF_0002);
    // Flush over a valid DIV store
    clr();
    flush = 1; ex_hilo_op = 2; ex_div_r = 32'h5; ex_div_q = 32'h6; ex_mem_we = 1; ex_alu_odata = 32'h44;
    go();
    chk("flush_valid", mem_valid, 0);
    chk("flush_mem_we", mem_mem_we, 0);
    chk("flush_result", mem_result, 0);
    chk("flush_hilo", {hi, lo}, 64'hCAFE_0001_BEEF_0002);
    // Flush together with stall holds prior contents
    clr();
    ex_alu_odata = 32'h3C; ex_mem_we = 1;
    go();
    stall = 1; flush = 1; ex_alu_odata = 32'h0;
    go();
    chk("stall_flush_valid", mem_valid, 1);
    chk("stall_flush_result", mem_result, 32'h3C);
    // Out-of-range select and HI/LO op codes
    clr();
    ex_res_sel = 6; ex_alu_odata = 32'h55; ex_hilo_op = 7; ex_rs_data = 32'hFFFF; ex_mult_data = '1;
    go();
    chk("sel6_result", mem_result, 32'h55);
    chk("op7_hilo", {hi, lo}, 64'hCAFE_0001_BEEF_0002);
    // Reset while stalled
    clr();
    stall = 1;
    go();
    mid_reset();
    // Random traffic with occasional mid-cycle reset
    for (int i = 0; i < 400; i++) begin
      rnd();
      go();
      if (i == 200) mid_reset();
    end
    clr();
    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
